status_commit_reader: RTL and testbench
=======================================

# status_commit_reader

In-order drain controller for the status valid vector: it watches the head entry (bit 0) of the vector's valid and status masks and hands each completed entry to a downstream consumer over a valid/ready handshake. On every accepted commit it issues the single-cycle `pull_i` strobe the vector needs to shift its head out. The block sits between the status valid vector and the commit/retire stage. The allocation side drives the vector's `push_i`; this block drives only its `pull_i`.

## Interface
- `DEPTH`, default 8: entries in the status valid vector; must be ≥ 2.
- `SEQ_W`, default 8: width of the commit sequence counter.
- `TIMEOUT`, default 255: head-wait cycles before `timeout_o` is set. Used only with `STATUS_COMMIT_TIMEOUT_EN`.
- `OCC_W`, default `$clog2(DEPTH+1)`: width of the occupancy count. Derived; do not override.
- `clk_i`, in, 1: clock; the block has one clock.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `valid_vec_i`, in, DEPTH: vector valid mask; thermometer-coded, bit 0 is the head.
- `status_vec_i`, in, DEPTH: per-entry "done" status.
- `flush_i`, in, 1: abandon the pending commit and return to IDLE.
- `pull_o`, out, 1: pull strobe to the vector, i.e. the vector's `pull_i`.
- `commit_valid_o`, out, 1: head entry is offered for commit.
- `commit_ready_i`, in, 1: downstream accepts the commit.
- `commit_seq_o`, out, SEQ_W: sequence number of the offered entry.
- `occupancy_o`, out, OCC_W: registered popcount of `valid_vec_i`.
- `timeout_o`, out, 1: sticky head-wait timeout flag.

## Operation
- **FSM states:** IDLE (head invalid), WAIT (head valid, status clear), ISSUE (head valid and done, offered).
- **IDLE → WAIT:** `valid_vec_i[0] & ~status_vec_i[0]`.
- **IDLE/WAIT → ISSUE:** `valid_vec_i[0] & status_vec_i[0]`.
- **WAIT → IDLE:** `~valid_vec_i[0]`. This is tolerated but not expected.
- **`commit_valid_o`:** equals `state == ISSUE`. While `commit_ready_i` is low, `commit_valid_o` and `commit_seq_o` stay stable.
- **Handshake:** `hs = commit_valid_o & commit_ready_i & ~flush_i`.
- **`pull_o`:** equals `hs` and is combinational. It is the only source of a pull, and is never asserted outside ISSUE.
- **On `hs`, sequence:** `commit_seq_o` increments by 1 modulo 2^SEQ_W, so 255 → 0 at `SEQ_W = 8`.
- **On `hs`, next state** (evaluated from entry 1, which becomes the head after the shift):
  - `valid_vec_i[1] & status_vec_i[1]` → stay in ISSUE (back-to-back commit).
  - `valid_vec_i[1]` only → WAIT.
  - Otherwise → IDLE.
- **Invalid entries:** status bits on invalid entries are ignored.
- **Pushes:** the vector resolves simultaneous push and pull itself; this block does not observe pushes.
- **`flush_i`:**
  - Has highest priority after reset.
  - In the flush cycle: `pull_o = 0`, no sequence increment, next state IDLE.
  - Downstream must ignore `commit_valid_o` in a cycle where `flush_i` is high.
  - `commit_seq_o` is not cleared by flush.
  - Clears `timeout_o`.
- **`occupancy_o`:** registered popcount of `valid_vec_i`; range 0..DEPTH.

## Timing
- **Reset values:** state IDLE, `commit_valid_o = 0`, `pull_o = 0`, `commit_seq_o = 0`, `occupancy_o = 0`, `timeout_o = 0`, timeout counter 0.
- **Reset mid-commit:** the pending commit is dropped with no pull.
- **Done-to-offer latency:** head becomes valid and done at edge N (seen by the FSM in cycle N); `commit_valid_o` is high from edge N+1.
- **Pull latency:** `pull_o` is high in the handshake cycle. The vector shifts at the following edge, and the new head is visible the cycle after that edge.
- **Throughput:** one commit per cycle while consecutive entries are done and ready is held high.
- **`occupancy_o` latency:** one cycle.

## Configuration
- **Macro:** `STATUS_COMMIT_TIMEOUT_EN`.
- **Defined:**
  - A counter runs while in WAIT and resets to 0 on leaving WAIT.
  - When the counter reaches `TIMEOUT`, `timeout_o` is set at the next edge.
  - `timeout_o` is sticky until `flush_i` or `rst_i`.
  - The counter saturates and does not wrap.
- **Undefined:** no counter logic; `timeout_o` is tied to 0.

## Test plan
- **Reset state:** hold `rst_i` high for 2 cycles with random inputs → all outputs 0 and state IDLE; after release, `commit_seq_o` is 0.
- **Single commit:** set `valid_vec_i = 8'h01` and `status_vec_i = 8'h01` at edge N, with `commit_ready_i = 1` → `commit_valid_o` high at N+1 with seq 0 and `pull_o` high in that same cycle; seq reads 1 afterwards.
- **Back-to-back:** `valid_vec_i = 8'h0F`, `status_vec_i = 8'h0F`, and the vector model shifts on each pull → 4 consecutive cycles with `pull_o` high, seq 0..3, then IDLE.
- **Backpressure:** with the head done, hold `commit_ready_i` low for 5 cycles → `commit_valid_o` stays high, seq is stable, `pull_o` stays 0; raising ready gives exactly one pull.
- **Flush:** in ISSUE, assert `flush_i` together with ready → `pull_o = 0`, state returns to IDLE, seq is unchanged.
- **Timeout (macro defined, `TIMEOUT = 4`):** head valid with status clear for 10 cycles → `timeout_o` rises after the 4th count and stays high until `flush_i`.

Source files
------------

// File: rtl/status_commit_reader.sv
// In-order drain controller for the status valid vector: offers each completed head entry
// downstream and strobes the vector's pull on every accepted commit. Optional head-wait
// timeout is built when STATUS_COMMIT_TIMEOUT_EN is defined.
module status_commit_reader #(
    parameter int DEPTH   = 8,
    parameter int SEQ_W   = 8,
    parameter int TIMEOUT = 255,
    parameter int OCC_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [DEPTH-1:0] valid_vec_i,
    input  logic [DEPTH-1:0] status_vec_i,
    input  logic             flush_i,
    output logic             pull_o,
    output logic             commit_valid_o,
    input  logic             commit_ready_i,
    output logic [SEQ_W-1:0] commit_seq_o,
    output logic [OCC_W-1:0] occupancy_o,
    output logic             timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [SEQ_W-1:0] seq_reg;
    logic [SEQ_W-1:0] seq_next;
    logic [OCC_W-1:0] occ_reg;
    logic [OCC_W-1:0] occ_next;
    logic             hs;

    logic head_valid;
    logic head_done;
    logic second_valid;
    logic second_done;
    logic status_unused;

    // Status bits only matter where the matching valid bit is set.
    assign head_valid    = valid_vec_i[0];
    assign head_done     = valid_vec_i[0] & status_vec_i[0];
    assign second_valid  = valid_vec_i[1];
    assign second_done   = valid_vec_i[1] & status_vec_i[1];
    assign status_unused = &{1'b0, status_vec_i};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; after a handshake entry 1 becomes the new head.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        if (flush_i) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE, ST_WAIT: begin
                    if (head_done) begin
                        state_next = ST_ISSUE;
                    end else if (head_valid) begin
                        state_next = ST_WAIT;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (hs) begin
                        if (second_done) begin
                            state_next = ST_ISSUE;
                        end else if (second_valid) begin
                            state_next = ST_WAIT;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        commit_valid_o = (state_reg == ST_ISSUE);
        hs             = commit_valid_o & commit_ready_i & ~flush_i;
        pull_o         = hs;
    end

    // ------------------------------------------------------------------
    // Commit sequence counter; wraps naturally, untouched by flush.
    // ------------------------------------------------------------------
    always_comb begin
        seq_next = seq_reg;
        if (hs) begin
            seq_next = seq_reg + SEQ_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            seq_reg <= '0;
        end else begin
            seq_reg <= seq_next;
        end
    end

    assign commit_seq_o = seq_reg;

    // ------------------------------------------------------------------
    // Occupancy: ripple popcount of the valid mask, registered once.
    // ------------------------------------------------------------------
    logic [OCC_W-1:0] pop_chain [0:DEPTH];

    assign pop_chain[0] = '0;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_popcount
            assign pop_chain[gi+1] = pop_chain[gi] + OCC_W'(valid_vec_i[gi]);
        end
    endgenerate

    assign occ_next = pop_chain[DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ_reg <= '0;
        end else begin
            occ_reg <= occ_next;
        end
    end

    assign occupancy_o = occ_reg;

    // ------------------------------------------------------------------
    // Head-wait timeout
    // ------------------------------------------------------------------
`ifdef STATUS_COMMIT_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

    logic [TO_W-1:0] to_cnt_reg;
    logic [TO_W-1:0] to_cnt_next;
    logic            timeout_reg;
    logic            timeout_next;

    // Counter is only non-zero while the FSM sits in WAIT; it saturates at TO_MAX.
    always_comb begin
        to_cnt_next = '0;
        if ((state_reg == ST_WAIT) && (state_next == ST_WAIT)) begin
            to_cnt_next = (to_cnt_reg == TO_MAX) ? to_cnt_reg : to_cnt_reg + TO_W'(1);
        end
    end

    always_comb begin
        timeout_next = timeout_reg;
        if (flush_i) begin
            timeout_next = 1'b0;
        end else if ((state_reg == ST_WAIT) && (to_cnt_reg == TO_MAX)) begin
            timeout_next = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            to_cnt_reg  <= '0;
            timeout_reg <= 1'b0;
        end else begin
            to_cnt_reg  <= to_cnt_next;
            timeout_reg <= timeout_next;
        end
    end

    assign timeout_o = timeout_reg;
`else
    // TIMEOUT stays a parameter so instantiations match both builds.
    assign timeout_o = 1'b0 & (TIMEOUT != 0);
`endif

endmodule

// File: tb/tb_status_commit_reader.sv
// Self-checking bench for status_commit_reader: a small vector model shifts on each pull,
// and expected commit sequence numbers are queued on load and popped on handshake.
module tb_status_commit_reader;

    localparam int DEPTH      = 8;
    localparam int SEQ_W      = 8;
    localparam int TB_TIMEOUT = 4;
    localparam int OCC_W      = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic [DEPTH-1:0] valid_vec;
    logic [DEPTH-1:0] status_vec;
    logic             flush;
    logic             pull;
    logic             commit_valid;
    logic             commit_ready;
    logic [SEQ_W-1:0] commit_seq;
    logic [OCC_W-1:0] occupancy;
    logic             timeout;

    int checks = 0;
    int errors = 0;

    logic [SEQ_W-1:0] exp_q[$];
    logic [SEQ_W-1:0] push_seq;

    status_commit_reader #(
        .DEPTH  (DEPTH),
        .SEQ_W  (SEQ_W),
        .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .valid_vec_i   (valid_vec),
        .status_vec_i  (status_vec),
        .flush_i       (flush),
        .pull_o        (pull),
        .commit_valid_o(commit_valid),
        .commit_ready_i(commit_ready),
        .commit_seq_o  (commit_seq),
        .occupancy_o   (occupancy),
        .timeout_o     (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time=%0t required < 200000", $time);
        $fatal(1, "watchdog expired");
    end

    // Advance one cycle; the vector model shifts its head out after a pulled cycle.
    task automatic next_cycle(input logic pulled);
        @(posedge clk);
        #1;
        if (pulled) begin
            valid_vec  = valid_vec >> 1;
            status_vec = status_vec >> 1;
        end
    endtask

    task automatic load(input logic [DEPTH-1:0] v, input logic [DEPTH-1:0] s, input int n_commits);
        valid_vec  = v;
        status_vec = s;
        for (int i = 0; i < n_commits; i++) begin
            exp_q.push_back(push_seq);
            push_seq = push_seq + 1'b1;
        end
    endtask

    // Run cycles with ready high until the vector is empty and nothing is offered.
    task automatic drain(input string name, input int max_cycles, output int pulls);
        logic             hs;
        logic [SEQ_W-1:0] exp;
        pulls = 0;
        for (int c = 0; c < max_cycles; c++) begin
            @(negedge clk);
            hs = commit_valid && commit_ready && !flush;
            checks++;
            if (pull !== hs) begin
                errors++;
                $display("FAIL %s_pull: cycle %0d pull_o=%b required %b", name, c, pull, hs);
            end
            if (hs) begin
                pulls++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s_extra: unexpected commit seq=%0d required none", name, commit_seq);
                end else begin
                    exp = exp_q.pop_front();
                    if (commit_seq !== exp) begin
                        errors++;
                        $display("FAIL %s_seq: commit_seq_o=%0d required %0d", name, commit_seq, exp);
                    end
                end
            end
            if (valid_vec == '0 && !commit_valid) begin
                next_cycle(hs);
                return;
            end
            next_cycle(hs);
        end
        errors++;
        $display("FAIL %s_bound: vector not drained, valid=%h required 00 within %0d cycles",
                 name, valid_vec, max_cycles);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid_vec = $urandom;
        status_vec = $urandom;
        flush = $urandom_range(0, 1);
        commit_ready = $urandom_range(0, 1);
        @(posedge clk);
        #1;
        for (int c = 0; c < 2; c++) begin
            valid_vec = $urandom;
            status_vec = $urandom;
            flush = $urandom_range(0, 1);
            commit_ready = $urandom_range(0, 1);
            @(negedge clk);
            checks++;
            if ({commit_valid, pull, commit_seq, occupancy, timeout} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: valid=%b pull=%b seq=%0d occ=%0d to=%b required all 0",
                         commit_valid, pull, commit_seq, occupancy, timeout);
            end
            next_cycle(1'b0);
        end
        rst = 1'b0;
        valid_vec = '0;
        status_vec = '0;
        flush = 1'b0;
        commit_ready = 1'b0;
        exp_q.delete();
        push_seq = '0;
        @(negedge clk);
        checks++;
        if (commit_seq !== '0 || commit_valid !== 1'b0 || occupancy !== '0) begin
            errors++;
            $display("FAIL reset_release: seq=%0d valid=%b occ=%0d required 0 0 0",
                     commit_seq, commit_valid, occupancy);
        end
        next_cycle(1'b0);
    endtask

    task automatic test_single_commit();
        logic [SEQ_W-1:0] exp;
        commit_ready = 1'b1;
        load(8'h01, 8'h01, 1);
        @(negedge clk);
        checks++;
        if (commit_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: commit_valid_o=%b required 0 in load cycle", commit_valid);
        end
        next_cycle(1'b0);
        @(negedge clk);
        exp = exp_q.pop_front();
        checks++;
        if (commit_valid !== 1'b1 || pull !== 1'b1 || commit_seq !== exp) begin
            errors++;
            $display("FAIL single_offer: valid=%b pull=%b seq=%0d required 1 1 %0d",
                     commit_valid, pull, commit_seq, exp);
        end
        checks++;
        if (occupancy !== OCC_W'(1)) begin
            errors++;
            $display("FAIL single_occ: occupancy_o=%0d required 1", occupancy);
        end
        next_cycle(1'b1);
        @(negedge clk);
        checks++;
        if (commit_seq !== push_seq || commit_valid !== 1'b0 || pull !== 1'b0) begin
            errors++;
            $display("FAIL single_after: seq=%0d valid=%b pull=%b required %0d 0 0",
                     commit_seq, commit_valid, pull, push_seq);
        end
        next_cycle(1'b0);
    endtask

    task automatic test_back_to_back();
        int               first = -1;
        int               last = -1;
        int               n = 0;
        logic             hs;
        logic [SEQ_W-1:0] exp;
        commit_ready = 1'b1;
        load(8'h0F, 8'h0F, 4);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            hs = commit_valid && commit_ready && !flush;
            if (c == 1) begin
                checks++;
                if (occupancy !== OCC_W'(4)) begin
                    errors++;
                    $display("FAIL b2b_occ: occupancy_o=%0d required 4", occupancy);
                end
            end
            checks++;
            if (pull !== hs) begin
                errors++;
                $display("FAIL b2b_pull: cycle %0d pull_o=%b required %b", c, pull, hs);
            end
            if (hs) begin
                n++;
                if (first < 0) first = c;
                last = c;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra: unexpected commit seq=%0d required none", commit_seq);
                end else begin
                    exp = exp_q.pop_front();
                    if (commit_seq !== exp) begin
                        errors++;
                        $display("FAIL b2b_seq: commit_seq_o=%0d required %0d", commit_seq, exp);
                    end
                end
            end
            next_cycle(hs);
        end
        checks++;
        if (n != 4 || (last - first) != 3) begin
            errors++;
            $display("FAIL b2b_burst: pulls=%0d span=%0d required 4 consecutive", n, last - first + 1);
        end
        @(negedge clk);
        checks++;
        if (commit_valid !== 1'b0 || commit_seq !== push_seq) begin
            errors++;
            $display("FAIL b2b_idle: valid=%b seq=%0d required 0 %0d", commit_valid, commit_seq, push_seq);
        end
        next_cycle(1'b0);
    endtask

    task automatic test_backpressure();
        int               pulls = 0;
        logic [SEQ_W-1:0] exp;
        commit_ready = 1'b0;
        load(8'h01, 8'h01, 1);
        @(negedge clk);
        next_cycle(1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (commit_valid !== 1'b1 || pull !== 1'b0 || commit_seq !== exp_q[0]) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d valid=%b pull=%b seq=%0d required 1 0 %0d",
                         c, commit_valid, pull, commit_seq, exp_q[0]);
            end
            next_cycle(1'b0);
        end
        commit_ready = 1'b1;
        @(negedge clk);
        exp = exp_q.pop_front();
        checks++;
        if (pull !== 1'b1 || commit_seq !== exp) begin
            errors++;
            $display("FAIL bp_release: pull=%b seq=%0d required 1 %0d", pull, commit_seq, exp);
        end
        if (pull === 1'b1) pulls++;
        next_cycle(pull);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (pull === 1'b1) pulls++;
            next_cycle(pull);
        end
        checks++;
        if (pulls != 1) begin
            errors++;
            $display("FAIL bp_once: pulls=%0d required 1", pulls);
        end
    endtask

    task automatic test_flush();
        int pulls;
        commit_ready = 1'b0;
        load(8'h01, 8'h01, 1);
        @(negedge clk);
        next_cycle(1'b0);
        flush = 1'b1;
        commit_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (pull !== 1'b0) begin
            errors++;
            $display("FAIL flush_pull: pull_o=%b required 0", pull);
        end
        next_cycle(1'b0);
        flush = 1'b0;
        commit_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (commit_valid !== 1'b0 || commit_seq !== exp_q[0]) begin
            errors++;
            $display("FAIL flush_idle: valid=%b seq=%0d required 0 %0d", commit_valid, commit_seq, exp_q[0]);
        end
        next_cycle(1'b0);
        commit_ready = 1'b1;
        drain("flush_redo", 6, pulls);
        checks++;
        if (pulls != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL flush_redo_count: pulls=%0d pending=%0d required 1 0", pulls, exp_q.size());
        end
    endtask

    task automatic test_wait_path();
        logic [SEQ_W-1:0] exp;
        commit_ready = 1'b1;
        load(8'h00, 8'hFF, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (commit_valid !== 1'b0 || pull !== 1'b0) begin
                errors++;
                $display("FAIL invalid_status: valid=%b pull=%b required 0 0", commit_valid, pull);
            end
            next_cycle(1'b0);
        end
        load(8'h03, 8'h01, 2);
        @(negedge clk);
        next_cycle(1'b0);
        @(negedge clk);
        exp = exp_q.pop_front();
        checks++;
        if (pull !== 1'b1 || commit_seq !== exp) begin
            errors++;
            $display("FAIL wait_first: pull=%b seq=%0d required 1 %0d", pull, commit_seq, exp);
        end
        next_cycle(pull);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (commit_valid !== 1'b0 || pull !== 1'b0) begin
                errors++;
                $display("FAIL wait_hold: cycle %0d valid=%b pull=%b required 0 0", c, commit_valid, pull);
            end
            next_cycle(1'b0);
        end
        status_vec = 8'h01;
        @(negedge clk);
        checks++;
        if (commit_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_latency: commit_valid_o=%b required 0", commit_valid);
        end
        next_cycle(1'b0);
        @(negedge clk);
        exp = exp_q.pop_front();
        checks++;
        if (commit_valid !== 1'b1 || pull !== 1'b1 || commit_seq !== exp) begin
            errors++;
            $display("FAIL wait_done: valid=%b pull=%b seq=%0d required 1 1 %0d",
                     commit_valid, pull, commit_seq, exp);
        end
        next_cycle(pull);
    endtask

    task automatic test_occupancy();
        logic [DEPTH-1:0] v;
        commit_ready = 1'b0;
        for (int k = 0; k <= DEPTH; k++) begin
            v = DEPTH'((9'h1 << k) - 9'h1);
            load(v, 8'h00, 0);
            next_cycle(1'b0);
            @(negedge clk);
            checks++;
            if (occupancy !== OCC_W'(k)) begin
                errors++;
                $display("FAIL occ_%0d: occupancy_o=%0d required %0d", k, occupancy, k);
            end
            next_cycle(1'b0);
        end
        load(8'h00, 8'h00, 0);
        next_cycle(1'b0);
    endtask

    task automatic test_timeout();
        logic exp;
        commit_ready = 1'b0;
        flush = 1'b1;
        next_cycle(1'b0);
        flush = 1'b0;
        load(8'h01, 8'h00, 0);
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
`ifdef STATUS_COMMIT_TIMEOUT_EN
            exp = (c >= 6);
`else
            exp = 1'b0;
`endif
            checks++;
            if (timeout !== exp || pull !== 1'b0) begin
                errors++;
                $display("FAIL timeout_c%0d: timeout_o=%b pull=%b required %b 0", c, timeout, pull, exp);
            end
            next_cycle(1'b0);
        end
        flush = 1'b1;
        next_cycle(1'b0);
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_flush: timeout_o=%b required 0", timeout);
        end
        load(8'h00, 8'h00, 0);
        next_cycle(1'b0);
    endtask

    task automatic test_seq_wrap();
        int pulls;
        int total = 0;
        commit_ready = 1'b1;
        for (int b = 0; b < 33; b++) begin
            load(8'hFF, 8'hFF, 8);
            drain("wrap", 20, pulls);
            total += pulls;
        end
        @(negedge clk);
        checks++;
        if (total != 264 || commit_seq !== push_seq || exp_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_total: commits=%0d seq=%0d pending=%0d required 264 %0d 0",
                     total, commit_seq, exp_q.size(), push_seq);
        end
        next_cycle(1'b0);
    endtask

    initial begin
        push_seq = '0;
        test_reset();
        test_single_commit();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_wait_path();
        test_timeout();
        test_occupancy();
        test_seq_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
